// File: rtl/conv_layer_pkg.sv
// conv_layer_pkg: shared definitions for the convolution layer datapath.
//   cmd_e        - controller -> input interface command codes
//   ack_e        - input interface -> controller acknowledge codes
//   ctrl_state_e - conv_layer_controller FSM states (4-bit encoding)
//   FLOAT32_ONE  - IEEE-754 single-precision 1.0
package conv_layer_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE          = 2'd0,
    CMD_PRELOAD_START = 2'd1,
    CMD_SHIFT_START   = 2'd2,
    CMD_LOAD_START    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ACK_IDLE        = 2'd0,
    ACK_PRELOAD_FIN = 2'd1,
    ACK_SHIFT_FIN   = 2'd2,
    ACK_LOAD_FIN    = 2'd3
  } ack_e;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_PRE_CMD    = 4'd1,
    S_PRE_WAIT   = 4'd2,
    S_SHIFT_CMD  = 4'd3,
    S_SHIFT_WAIT = 4'd4,
    S_LOAD_CMD   = 4'd5,
    S_LOAD_WAIT  = 4'd6,
    S_DONE       = 4'd7,
    S_ERROR      = 4'd8
  } ctrl_state_e;

  localparam logic [31:0] FLOAT32_ONE = 32'h3F80_0000;

endpackage

// File: rtl/conv_layer_controller_if.sv
// conv_layer_controller_if: command/acknowledge link between the controller
// and conv_layer_input_interface.
//   cmd - command issued by the controller (master drives)
//   ack - completion code returned by the input interface (slave drives)
interface conv_layer_controller_if;
  import conv_layer_pkg::*;

  cmd_e cmd;
  ack_e ack;

  modport master (output cmd, input ack);
  modport slave  (input cmd, output ack);

endinterface

// File: rtl/conv_layer_controller.sv
// conv_layer_controller: sequences one convolution pass over an image by
// commanding the input interface: one preload, NUM_WEIGHT_SETS shifts per
// output row, and one row load between output rows.
// Optional feature: define CONV_CTRL_TIMEOUT_EN to build an ack watchdog that
// parks the FSM in S_ERROR and raises a sticky error flag.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - global advance enable; all state holds while low
//   start       - begin an image pass (sampled in S_IDLE only)
//   link        - cmd/ack link to the input interface (master side)
//   row_idx     - current output row
//   ws_idx      - current weight set
//   busy        - high in every state except S_IDLE
//   shift_done  - pulse when SHIFT_FIN is accepted; row_idx/ws_idx valid
//   done        - pulse at end of image
//   error       - sticky watchdog flag (0 unless CONV_CTRL_TIMEOUT_EN)
module conv_layer_controller
  import conv_layer_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE     = 3,
  parameter int unsigned IMAGE_SIZE      = 8,
  parameter int unsigned OUT_ROWS        = IMAGE_SIZE - KERNEL_SIZE + 1,
  parameter int unsigned NUM_WEIGHT_SETS = 2,
  parameter int unsigned ROW_WIDTH       = 3,
  parameter int unsigned WS_WIDTH        = 2
`ifdef CONV_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES  = 255
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          start,
  conv_layer_controller_if.master       link,
  output logic [ROW_WIDTH-1:0]          row_idx,
  output logic [WS_WIDTH-1:0]           ws_idx,
  output logic                          busy,
  output logic                          shift_done,
  output logic                          done,
  output logic                          error
);

  localparam logic [ROW_WIDTH-1:0] LastRow = ROW_WIDTH'(OUT_ROWS - 1);
  localparam logic [WS_WIDTH-1:0]  LastWs  = WS_WIDTH'(NUM_WEIGHT_SETS - 1);

  ctrl_state_e          state_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [WS_WIDTH-1:0]  ws_q;
  logic                 timeout;

`ifdef CONV_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       waiting;

  assign waiting = (state_q == S_PRE_WAIT) || (state_q == S_SHIFT_WAIT) ||
                   (state_q == S_LOAD_WAIT);

  // Held at zero outside the wait states, so every wait starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (enable) begin
      if (!waiting) wait_cnt_q <= '0;
      else          wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // Fires on the enabled cycle whose increment would reach the limit.
  assign timeout = waiting && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign error   = (state_q == S_ERROR);
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      ws_q    <= '0;
    end else if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_PRE_CMD;
            row_q   <= '0;
            ws_q    <= '0;
          end
        end
        S_PRE_CMD: state_q <= S_PRE_WAIT;
        S_PRE_WAIT: begin
          if (link.ack == ACK_PRELOAD_FIN) state_q <= S_SHIFT_CMD;
          else if (timeout)                state_q <= S_ERROR;
        end
        S_SHIFT_CMD: state_q <= S_SHIFT_WAIT;
        S_SHIFT_WAIT: begin
          if (link.ack == ACK_SHIFT_FIN) begin
            if (ws_q < LastWs) begin
              ws_q    <= ws_q + WS_WIDTH'(1);
              state_q <= S_SHIFT_CMD;
            end else if (row_q < LastRow) begin
              ws_q    <= '0;
              state_q <= S_LOAD_CMD;
            end else begin
              state_q <= S_DONE;
            end
          end else if (timeout) begin
            state_q <= S_ERROR;
          end
        end
        S_LOAD_CMD: state_q <= S_LOAD_WAIT;
        S_LOAD_WAIT: begin
          if (link.ack == ACK_LOAD_FIN) begin
            row_q   <= row_q + ROW_WIDTH'(1);
            state_q <= S_SHIFT_CMD;
          end else if (timeout) begin
            state_q <= S_ERROR;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The interface re-acts to a held command, so a command lives for exactly
  // one enabled cycle: the *_CMD state always leaves on that same edge.
  always_comb begin
    link.cmd = CMD_IDLE;
    if (enable) begin
      case (state_q)
        S_PRE_CMD:   link.cmd = CMD_PRELOAD_START;
        S_SHIFT_CMD: link.cmd = CMD_SHIFT_START;
        S_LOAD_CMD:  link.cmd = CMD_LOAD_START;
        default:     link.cmd = CMD_IDLE;
      endcase
    end
  end

  // Strobes mark the accepting cycle, so row/ws still describe that pass.
  assign shift_done = enable && (state_q == S_SHIFT_WAIT) && (link.ack == ACK_SHIFT_FIN);
  assign done       = enable && (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign row_idx    = row_q;
  assign ws_idx     = ws_q;

endmodule

// File: tb/tb_conv_layer_controller.sv
// tb_conv_layer_controller: self-checking bench for conv_layer_controller.
// A behavioural input-interface model answers each command after a latency,
// and a pass-level reference (expected command list, expected (row,ws) list)
// predicts cmd, strobes and busy every cycle.
module tb_conv_layer_controller;
  import conv_layer_pkg::*;

  localparam int OutRows = 6;
  localparam int NumWs   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       start;
  logic [2:0] row_idx;
  logic [1:0] ws_idx;
  logic       busy;
  logic       shift_done;
  logic       done;
  logic       error;

  int n_vec;
  int n_err;

  conv_layer_controller_if link ();

  conv_layer_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .link       (link),
    .row_idx    (row_idx),
    .ws_idx     (ws_idx),
    .busy       (busy),
    .shift_done (shift_done),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    start    = 1'b0;
    link.ack = ACK_IDLE;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    #1;
    check("rst_cmd", link.cmd, CMD_IDLE);
    check("rst_row", row_idx, 0);
    check("rst_ws", ws_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_shift_done", shift_done, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b0;
  endtask

  // rnd: random enable/latency/spurious acks/ignored starts
  // hold_load: after the first LOAD_FIN keep enable low for 4 cycles
  // start_row2: pulse start whenever row 2 is current
  // abort_row: assert reset once this row is current (-1: never)
  task automatic run_pass(input bit rnd, input bit hold_load, input bit start_row2,
                          input int abort_row);
    cmd_e       exp_q[$];
    logic [4:0] sd_q[$];
    int         cnt[4];
    bit         pending, cmd_due, done_due, exp_busy, finished, aborted, held, post_hold;
    bit         en, st, deliver, exp_sd, exp_dn;
    int         lat, hold_left;
    ack_e       pend_ack, a;
    cmd_e       exp_c;
    logic [1:0] code;

    exp_q.push_back(CMD_PRELOAD_START);
    for (int r = 0; r < OutRows; r++) begin
      for (int w = 0; w < NumWs; w++) begin
        exp_q.push_back(CMD_SHIFT_START);
        sd_q.push_back({3'(r), 2'(w)});
      end
      if (r < OutRows - 1) exp_q.push_back(CMD_LOAD_START);
    end
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    pending = 0; cmd_due = 0; done_due = 0; exp_busy = 0; finished = 0;
    aborted = 0; held = 0; post_hold = 0; lat = 0; hold_left = 0;
    pend_ack = ACK_IDLE;

    for (int cyc = 0; cyc < 5000 && !finished && !aborted; cyc++) begin
      @(negedge clk);
      if (abort_row >= 0 && exp_busy && row_idx == 3'(abort_row)) begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        start    = 1'b0;
        link.ack = ACK_IDLE;
        #1;
        check("abort_row", row_idx, 0);
        check("abort_ws", ws_idx, 0);
        check("abort_cmd", link.cmd, CMD_IDLE);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1;
        continue;
      end

      en = 1'b1;
      if (cyc != 0) begin
        if (hold_left > 0) begin
          en = 1'b0;
          hold_left--;
        end else if (rnd && $urandom_range(0, 4) == 0) begin
          en = 1'b0;
        end
      end
      st = (cyc == 0) || (start_row2 && exp_busy && row_idx == 3'd2) ||
           (rnd && exp_busy && $urandom_range(0, 7) == 0);

      a       = ACK_IDLE;
      deliver = 0;
      if (pending) begin
        if (lat > 0) lat--;
        if (lat == 0 && en) begin
          a       = pend_ack;
          deliver = 1;
        end else if (rnd && $urandom_range(0, 1) == 1) begin
          a = pend_ack;
          while (a == pend_ack) a = ack_e'($urandom_range(1, 3));
        end
      end else if (rnd) begin
        a = ack_e'($urandom_range(0, 3));
      end

      enable   = en;
      start    = st;
      link.ack = a;
      #1;

      exp_c = CMD_IDLE;
      if (cmd_due && en && exp_q.size() > 0) exp_c = exp_q[0];
      check("cmd", link.cmd, exp_c);
      if (post_hold && en) begin
        check("hold_shift", link.cmd, CMD_SHIFT_START);
        post_hold = 0;
      end
      exp_sd = deliver && (pend_ack == ACK_SHIFT_FIN);
      check("shift_done", shift_done, exp_sd);
      if (exp_sd && sd_q.size() > 0) check("row_ws", {row_idx, ws_idx}, sd_q.pop_front());
      exp_dn = done_due && en;
      check("done", done, exp_dn);
      check("busy", busy, exp_busy);
      check("error", error, 0);
      if (link.cmd != CMD_IDLE) cnt[int'(link.cmd)]++;

      // Reference model advance.
      if (st && en && !exp_busy) begin
        exp_busy = 1;
        cmd_due  = 1;
      end else if (cmd_due && en && exp_q.size() > 0) begin
        code     = exp_c;
        pend_ack = ack_e'(code);
        void'(exp_q.pop_front());
        cmd_due  = 0;
        pending  = 1;
        lat      = rnd ? int'($urandom_range(1, 4)) : 3;
      end
      if (deliver) begin
        pending = 0;
        if (exp_q.size() == 0) done_due = 1;
        else                   cmd_due  = 1;
        if (hold_load && !held && pend_ack == ACK_LOAD_FIN) begin
          held      = 1;
          hold_left = 4;
          post_hold = 1;
        end
      end
      if (exp_dn) begin
        done_due = 0;
        exp_busy = 0;
        finished = 1;
      end
    end

    if (!aborted) begin
      check("pass_end", finished, 1);
      @(negedge clk);
      enable   = 1'b1;
      start    = 1'b0;
      link.ack = ACK_IDLE;
      #1;
      check("busy_after", busy, 0);
      check("cmd_after", link.cmd, CMD_IDLE);
      check("n_preload", cnt[1], 1);
      check("n_shift", cnt[2], OutRows * NumWs);
      check("n_load", cnt[3], OutRows - 1);
    end
  endtask

`ifdef CONV_CTRL_TIMEOUT_EN
  task automatic timeout_test();
    apply_reset();
    @(negedge clk);
    enable   = 1'b1;
    start    = 1'b1;
    link.ack = ACK_IDLE;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("to_preload", link.cmd, CMD_PRELOAD_START);
    @(negedge clk);
    link.ack = ACK_PRELOAD_FIN;
    @(negedge clk);
    link.ack = ACK_IDLE;
    #1;
    check("to_shift", link.cmd, CMD_SHIFT_START);
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      #1;
      check("to_wait_error", error, 0);
      check("to_wait_cmd", link.cmd, CMD_IDLE);
    end
    @(negedge clk);
    #1;
    check("to_error", error, 1);
    check("to_busy", busy, 1);
    check("to_cmd", link.cmd, CMD_IDLE);
    repeat (3) @(negedge clk);
    #1;
    check("to_sticky", error, 1);
    rst_n = 1'b0;
    #1;
    check("to_clear", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    apply_reset();
    run_pass(1'b0, 1'b0, 1'b0, -1);
    run_pass(1'b0, 1'b1, 1'b0, -1);
    run_pass(1'b1, 1'b0, 1'b1, -1);
    run_pass(1'b1, 1'b1, 1'b0, -1);
    run_pass(1'b0, 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable   = 1'b1;
      start    = 1'b0;
      link.ack = ACK_IDLE;
      #1;
      check("post_abort_cmd", link.cmd, CMD_IDLE);
      check("post_abort_busy", busy, 0);
    end
    run_pass(1'b0, 1'b0, 1'b0, -1);
    run_pass(1'b1, 1'b0, 1'b0, -1);
`ifdef CONV_CTRL_TIMEOUT_EN
    timeout_test();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
